// File: rtl/cordic_trivial_rot.sv
// Trivial CORDIC rotation by multiples of 90 degrees with a frame-position counter.
// Optional macro CORDIC_ROT_SAT_EN saturates negation of the most negative value and flags oSat.
module cordic_trivial_rot #(
  parameter int unsigned DW    = 37,
  parameter int unsigned CNT_W = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iValid,
  input  logic [DW-1:0] iReal,
  input  logic [DW-1:0] iImage,
  input  logic [1:0]    iRot,
  input  logic          iUseCnt,
  input  logic          iClear,
  output logic          oValid,
  output logic [DW-1:0] oReal,
  output logic [DW-1:0] oImage,
  output logic          oFrameStart,
  output logic          oSat
);

  localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tag;
  logic [1:0]       effRot;

  logic             s1Valid;
  logic [DW-1:0]    s1Real;
  logic [DW-1:0]    s1Image;
  logic [1:0]       s1Rot;
  logic [CNT_W-1:0] s1Tag;

  logic [DW-1:0]    negReal;
  logic [DW-1:0]    negImage;
  logic [DW-1:0]    rotReal;
  logic [DW-1:0]    rotImage;

  // A clear arriving with a sample restarts the frame at that sample.
  always_comb begin
    tag    = iClear ? '0 : cnt;
    effRot = iUseCnt ? {1'b0, tag[CNT_W-1]} : iRot;
  end

`ifdef CORDIC_ROT_SAT_EN
  localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  logic realMin;
  logic imageMin;
  logic rotSat;

  always_comb begin
    realMin  = (s1Real == MinVal);
    imageMin = (s1Image == MinVal);
    negReal  = realMin  ? MaxVal : DW'(-s1Real);
    negImage = imageMin ? MaxVal : DW'(-s1Image);
    rotSat   = 1'b0;
    case (s1Rot)
      2'd1:    rotSat = realMin;
      2'd2:    rotSat = realMin | imageMin;
      2'd3:    rotSat = imageMin;
      default: rotSat = 1'b0;
    endcase
  end
`else
  always_comb begin
    negReal  = DW'(-s1Real);
    negImage = DW'(-s1Image);
  end
`endif

  // Quarter-turn selection on the stage-1 sample.
  always_comb begin
    rotReal  = s1Real;
    rotImage = s1Image;
    case (s1Rot)
      2'd1: begin
        rotReal  = s1Image;
        rotImage = negReal;
      end
      2'd2: begin
        rotReal  = negReal;
        rotImage = negImage;
      end
      2'd3: begin
        rotReal  = negImage;
        rotImage = s1Real;
      end
      default: begin
        rotReal  = s1Real;
        rotImage = s1Image;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      s1Valid     <= 1'b0;
      s1Real      <= '0;
      s1Image     <= '0;
      s1Rot       <= '0;
      s1Tag       <= '0;
      oValid      <= 1'b0;
      oReal       <= '0;
      oImage      <= '0;
      oFrameStart <= 1'b0;
      oSat        <= 1'b0;
    end else begin
      if (iClear) begin
        cnt <= iValid ? CNT_W'(1) : '0;
      end else if (iValid) begin
        cnt <= cnt + CNT_W'(1);
      end

      s1Valid <= iValid;
      if (iValid) begin
        s1Real  <= iReal;
        s1Image <= iImage;
        s1Rot   <= effRot;
        s1Tag   <= tag;
      end

      // Data outputs hold across bubbles; only valid/frame-start drop.
      oValid      <= s1Valid;
      oFrameStart <= s1Valid && (s1Tag == '0);
      if (s1Valid) begin
        oReal  <= rotReal;
        oImage <= rotImage;
`ifdef CORDIC_ROT_SAT_EN
        oSat   <= rotSat;
`else
        oSat   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cordic_trivial_rot.sv
// Scoreboard bench for cordic_trivial_rot: instance A (DW=8, CNT_W=1), instance B (DW=8, CNT_W=2).
module tb_cordic_trivial_rot;

  localparam int unsigned DW = 8;
`ifdef CORDIC_ROT_SAT_EN
  localparam int SatOn = 1;
`else
  localparam int SatOn = 0;
`endif

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 fs;
    logic                 sat;
    int                   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          aVal, aUse, aClr, bVal, bUse, bClr;
  logic [DW-1:0] aRe, aIm, bRe, bIm;
  logic [1:0]    aRot, bRot;
  logic          aOVal, aOFs, aOSat, bOVal, bOFs, bOSat;
  logic [DW-1:0] aORe, aOIm, bORe, bOIm;

  cordic_trivial_rot #(.DW(DW), .CNT_W(1)) dutA (
    .clk(clk), .rst(rst), .iValid(aVal), .iReal(aRe), .iImage(aIm), .iRot(aRot),
    .iUseCnt(aUse), .iClear(aClr), .oValid(aOVal), .oReal(aORe), .oImage(aOIm),
    .oFrameStart(aOFs), .oSat(aOSat)
  );

  cordic_trivial_rot #(.DW(DW), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .iValid(bVal), .iReal(bRe), .iImage(bIm), .iRot(bRot),
    .iUseCnt(bUse), .iClear(bClr), .oValid(bOVal), .oReal(bORe), .oImage(bOIm),
    .oFrameStart(bOFs), .oSat(bOSat)
  );

  int   cyc = 0;
  int   nCmp = 0;
  int   nBad = 0;
  bit   monOn = 1'b0;
  exp_t qA[$];
  exp_t qB[$];
  logic signed [DW-1:0] lastRe[2];
  logic signed [DW-1:0] lastIm[2];
  logic                 lastSat[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int expv);
    nCmp++;
    if (act != expv) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkOut(input int inst, input logic ov, input logic [DW-1:0] ore,
                          input logic [DW-1:0] oim, input logic ofs, input logic osat);
    exp_t  e;
    bit    empty;
    string n;
    n = (inst == 0) ? "A" : "B";
    if (ov) begin
      empty = (inst == 0) ? (qA.size() == 0) : (qB.size() == 0);
      if (empty) begin
        nCmp++;
        nBad++;
        $display("FAIL %s.unexpected_valid: got oValid=1 expected no output (cycle %0d)", n, cyc);
      end else begin
        if (inst == 0) e = qA.pop_front();
        else           e = qB.pop_front();
        cmp({n, ".latency"}, cyc, e.due);
        cmp({n, ".real"}, int'($signed(ore)), int'(e.re));
        cmp({n, ".image"}, int'($signed(oim)), int'(e.im));
        cmp({n, ".frameStart"}, int'(ofs), int'(e.fs));
        cmp({n, ".sat"}, int'(osat), int'(e.sat));
        lastRe[inst]  = e.re;
        lastIm[inst]  = e.im;
        lastSat[inst] = e.sat;
      end
    end else begin
      cmp({n, ".idle_frameStart"}, int'(ofs), 0);
      cmp({n, ".hold_real"}, int'($signed(ore)), int'(lastRe[inst]));
      cmp({n, ".hold_image"}, int'($signed(oim)), int'(lastIm[inst]));
      cmp({n, ".hold_sat"}, int'(osat), int'(lastSat[inst]));
    end
  endtask

  // Monitor: pops expectations whenever an instance presents a valid output.
  always @(negedge clk) begin
    if (monOn) begin
      checkOut(0, aOVal, aORe, aOIm, aOFs, aOSat);
      checkOut(1, bOVal, bORe, bOIm, bOFs, bOSat);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          lastRe[k]  = '0;
          lastIm[k]  = '0;
          lastSat[k] = 1'b0;
        end
      end
    end
  end

  task automatic step(input int inst, input int v, input int r, input int i, input int rot,
                      input int uc, input int clr, input int rs, input int push,
                      input int er, input int ei, input int efs, input int esat);
    exp_t e;
    @(posedge clk);
    #1;
    rst  = 1'(rs);
    aVal = 1'b0;
    aClr = 1'b0;
    bVal = 1'b0;
    bClr = 1'b0;
    if (inst == 0) begin
      aVal = 1'(v);  aRe = DW'(r); aIm = DW'(i); aRot = 2'(rot); aUse = 1'(uc); aClr = 1'(clr);
    end else begin
      bVal = 1'(v);  bRe = DW'(r); bIm = DW'(i); bRot = 2'(rot); bUse = 1'(uc); bClr = 1'(clr);
    end
    if (push != 0) begin
      e.re  = DW'(er);
      e.im  = DW'(ei);
      e.fs  = 1'(efs);
      e.sat = 1'(esat);
      e.due = cyc + 2;
      if (inst == 0) qA.push_back(e);
      else           qB.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    aVal = 1'b0; aUse = 1'b0; aClr = 1'b0; aRe = '0; aIm = '0; aRot = '0;
    bVal = 1'b0; bUse = 1'b0; bClr = 1'b0; bRe = '0; bIm = '0; bRot = '0;
    for (int k = 0; k < 2; k++) begin
      lastRe[k] = '0; lastIm[k] = '0; lastSat[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 monOn = 1'b1;

    // First cycle after reset: x-j on (5,3), tag 0.
    step(0, 1, 5, 3, 1, 0, 0, 0, 1, 3, -5, 1, 0);
    idle(3);

    // Counter-driven rotation over two frames; iRot must be ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 2, 1, 0, 0, 1, 1, 2, 1, 0);
    step(0, 1, 3, 4, 2, 1, 0, 0, 1, 4, -3, 0, 0);
    step(0, 1, 5, 6, 2, 1, 0, 0, 1, 5, 6, 1, 0);
    step(0, 1, 7, 8, 2, 1, 0, 0, 1, 8, -7, 0, 0);
    idle(2);

    // Most-negative value through every code.
    step(0, 1, -128, 7, 2, 0, 0, 0, 1, SatOn ? 127 : -128, -7, 1, SatOn);
    step(0, 1, -128, -128, 0, 0, 0, 0, 1, -128, -128, 0, 0);
    step(0, 1, -128, 5, 3, 0, 0, 0, 1, -5, -128, 1, 0);
    step(0, 1, 100, -128, 1, 0, 0, 0, 1, -128, -100, 0, 0);
    step(0, 1, 3, -128, 3, 0, 0, 0, 1, SatOn ? 127 : -128, 3, 1, SatOn);
    step(0, 1, -128, -128, 2, 0, 0, 0, 1, SatOn ? 127 : -128, SatOn ? 127 : -128, 0, SatOn);
    step(0, 1, 127, -127, 2, 0, 0, 0, 1, -127, 127, 1, 0);
    idle(2);

    // Alternating valid/bubble with x+j.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 2, -9, 3, 0, 0, 0, 1, 9, 2, (k % 2), 0);
      idle(1);
    end
    idle(2);

    // CNT_W=2: clear together with a valid sample restarts the frame.
    step(1, 1, 10, 11, 0, 0, 0, 0, 1, 10, 11, 1, 0);
    step(1, 1, 12, 13, 0, 0, 0, 0, 1, 12, 13, 0, 0);
    step(1, 1, 14, 15, 0, 1, 0, 0, 1, 15, -14, 0, 0);
    step(1, 1, 16, 17, 0, 0, 1, 0, 1, 16, 17, 1, 0);
    step(1, 1, 18, 19, 0, 0, 0, 0, 1, 18, 19, 0, 0);
    step(1, 1, 20, 21, 0, 1, 0, 0, 1, 21, -20, 0, 0);
    idle(3);

    // One-cycle reset mid-stream; the two samples just before it are discarded.
    step(0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 1, 2, 2, 0, 0, 0, 0, 1, 2, 2, 1, 0);
    step(0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 0, 0, 0, 1, 5, 5, 1, 0);
    step(0, 1, 6, 6, 2, 0, 0, 0, 1, -6, -6, 0, 0);
    idle(1);

    for (int k = 0; k < 20 && (qA.size() != 0 || qB.size() != 0); k++) idle(1);
    idle(1);
    cmp("A.drain_pending", qA.size(), 0);
    cmp("B.drain_pending", qB.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
